// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator.
// Contents:
//   PROD_W     width of the signed multiplier product feeding the accumulator
//   ACC_W_DEF  default accumulator / result width
//   CNT_W_DEF  default beat-counter width
//   state_e    accumulator FSM states
package product_accumulator_pkg;

  localparam int PROD_W    = 40;
  localparam int ACC_W_DEF = 48;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Saturating adder: acc + sign-extended product, evaluated one bit wider than
// the accumulator and clamped to the signed ACC_W range.
// Ports:
//   acc   in   ACC_W   current accumulator (signed)
//   prod  in   PROD_W  product to add (signed)
//   sum   out  ACC_W   clamped sum
//   ovf   out  1       high when the clamp was applied
module sat_add
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};

  // The extra top bit disagrees with the ACC_W sign bit only when the true
  // sum left the representable range; its value tells which way.
  always_comb begin
    sum = wide[ACC_W-1:0];
    ovf = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for signed multiplier products. Beats are summed with
// saturation until a beat marked last; the frame result (sum, beat count,
// sticky overflow) is then held until downstream takes it.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      product beat present
//   in_ready   out  1      beat accepted this cycle (state only)
//   in_prod    in   40     signed product
//   in_last    in   1      final beat of the frame
//   out_valid  out  1      frame result present
//   out_ready  in   1      downstream takes the result
//   out_sum    out  ACC_W  saturated frame sum
//   out_count  out  CNT_W  beats in the frame, saturating
//   out_ovf    out  1      saturation occurred in the frame
//
// state | meaning
// ACCUM | summing beats, in_ready=1
// HOLD  | result presented, waiting for out_ready
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] acc_nxt;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             accept;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (acc_nxt),
    .ovf  (add_ovf)
  );

  // Handshake outputs come from state; rst only masks them so nothing is
  // advertised before the first reset edge has settled the FSM.
  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD) && !rst;
  assign accept    = in_valid && in_ready;

  assign cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign ovf_nxt = ovf | add_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (in_last) begin
              out_sum   <= acc_nxt;
              out_count <= cnt_nxt;
              out_ovf   <= ovf_nxt;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int AW_A = 42;
  localparam int CW_A = 16;
  localparam int AW_B = 64;
  localparam int CW_B = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_prod_dummy;
  logic [39:0] in_prod;
  logic in_last;
  logic out_ready;

  logic            ready_a, valid_a, ovf_a;
  logic [AW_A-1:0] sum_a;
  logic [CW_A-1:0] count_a;
  logic            ready_b, valid_b, ovf_b;
  logic [AW_B-1:0] sum_b;
  logic [CW_B-1:0] count_b;

  int nchecks = 0;
  int nerr    = 0;

  logic signed [39:0] frame_q[$];

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(valid_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_count(count_a), .out_ovf(ovf_a)
  );

  product_accumulator #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(valid_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_count(count_b), .out_ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx_a(input logic [AW_A-1:0] v);
    longint t;
    t = $signed(v);
    return t;
  endfunction

  // Reference: frame sum from plain arithmetic, clamped after every beat.
  task automatic run_frame(input int hold, input bit busy, input logic signed [39:0] nxt);
    longint maxv, minv, s, s64;
    int     n;
    bit     ov;
    maxv = (64'sd1 <<< (AW_A - 1)) - 1;
    minv = -(64'sd1 <<< (AW_A - 1));
    s = 0; s64 = 0; n = 0; ov = 0;
    foreach (frame_q[i]) begin
      chk("beat_ready", {63'd0, ready_a & ready_b}, 64'd1);
      in_valid = 1'b1;
      in_prod  = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
      s   = s + longint'(frame_q[i]);
      s64 = s64 + longint'(frame_q[i]);
      if (s > maxv) begin s = maxv; ov = 1; end
      if (s < minv) begin s = minv; ov = 1; end
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_valid", {62'd0, valid_a, valid_b}, 64'd3);
    chk("hold_ready", {62'd0, ready_a, ready_b}, 64'd0);
    chk("sum_a", sx_a(sum_a), s);
    chk("count_a", 64'(count_a), 64'(n));
    chk("ovf_a", 64'(ovf_a), 64'(ov));
    chk("sum_b", sum_b, s64);
    chk("count_b", 64'(count_b), 64'((n > 7) ? 7 : n));
    chk("ovf_b", 64'(ovf_b), 64'd0);
    if (hold > 0) begin
      out_ready = 1'b0;
      if (busy) begin
        in_valid = 1'b1;
        in_prod  = nxt;
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("stall_valid", {62'd0, valid_a, valid_b}, 64'd3);
        chk("stall_ready", {62'd0, ready_a, ready_b}, 64'd0);
        chk("stall_sum_a", sx_a(sum_a), s);
        chk("stall_count_a", 64'(count_a), 64'(n));
        chk("stall_ovf_a", 64'(ovf_a), 64'(ov));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_valid", {62'd0, valid_a, valid_b}, 64'd0);
    chk("release_ready", {62'd0, ready_a, ready_b}, 64'd3);
  endtask

  initial begin
    logic [63:0] r;
    int len;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
    in_prod_dummy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {62'd0, valid_a, valid_b}, 64'd0);
    chk("rst_ready", {62'd0, ready_a, ready_b}, 64'd0);
    chk("rst_sum", sum_a | sum_b[41:0], 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_ovf", {62'd0, ovf_a, ovf_b}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {62'd0, ready_a, ready_b}, 64'd3);

    // basic three-beat frame
    frame_q = '{40'sd100, -40'sd30, 40'sd5};
    run_frame(0, 0, '0);
    chk("basic_sum_75", sx_a(sum_a), 64'd75);

    // positive saturation, then negative frames
    frame_q = {};
    for (int i = 0; i < 8; i++) frame_q.push_back(40'sd1 <<< 38);
    run_frame(0, 0, '0);
    frame_q = {};
    for (int i = 0; i < 8; i++) frame_q.push_back(-(40'sd1 <<< 38));
    run_frame(0, 0, '0);
    frame_q = {};
    for (int i = 0; i < 9; i++) frame_q.push_back(-(40'sd1 <<< 38));
    run_frame(0, 0, '0);

    // stalled result with upstream pushing; held beat starts next frame
    frame_q = '{40'sd11, 40'sd22};
    run_frame(5, 1, 40'sd1000);
    frame_q = '{40'sd1000, -40'sd1};
    run_frame(0, 0, '0);

    // single beat then back-to-back
    frame_q = '{-40'sd7};
    run_frame(0, 0, '0);
    frame_q = '{40'sd3, 40'sd4};
    run_frame(0, 0, '0);

    // counter saturation on the narrow instance
    frame_q = {};
    for (int i = 0; i < 10; i++) frame_q.push_back(40'(i));
    run_frame(1, 0, '0);

    // random frames
    for (int f = 0; f < 8; f++) begin
      frame_q = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = {$urandom(), $urandom()};
        frame_q.push_back(r[39:0]);
      end
      run_frame($urandom_range(0, 3), 0, '0);
    end

    // reset mid-frame discards the partial result
    in_valid = 1'b1; in_prod = 40'sd50; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {62'd0, valid_a, valid_b}, 64'd0);
    chk("midrst_ready", {62'd0, ready_a, ready_b}, 64'd0);
    chk("midrst_count", 64'(count_a), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", {62'd0, ready_a, ready_b}, 64'd3);
    @(posedge clk); #1;
    chk("midrst_no_emit", {62'd0, valid_a, valid_b}, 64'd0);
    frame_q = '{40'sd1, 40'sd1};
    run_frame(0, 0, '0);
    chk("after_rst_sum_2", sx_a(sum_a), 64'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
